// File: rtl/io_input_conditioner_if.sv
// Raw switch/button levels in, debounced levels and button press events out.
interface io_input_conditioner_if;
  logic [15:0] sw_raw;
  logic        btnr_raw;
  logic        event_clear;
  logic [15:0] sw_clean;
  logic        btnr_clean;
  logic        btnr_pulse;
  logic        btnr_event;
  logic [7:0]  press_count;

  modport master (
    output sw_raw, btnr_raw, event_clear,
    input  sw_clean, btnr_clean, btnr_pulse, btnr_event, press_count
  );

  modport slave (
    input  sw_raw, btnr_raw, event_clear,
    output sw_clean, btnr_clean, btnr_pulse, btnr_event, press_count
  );
endinterface

// File: rtl/io_input_conditioner.sv
// Synchronizes and debounces 16 switches plus the right button, and derives
// press pulse / sticky event / wrapping press count from the clean button.
module io_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input logic                   clock,
  input logic                   ctrl_reset,
  io_input_conditioner_if.slave io
);

  localparam int NCH = 17;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // Channel 16 is the button; channels 15..0 are the switches.
  logic [NCH-1:0] raw_bus;
  logic [NCH-1:0] clean_reg;
  logic [NCH-1:0] clean_next;

  assign raw_bus = {io.btnr_raw, io.sw_raw};

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi = gi + 1) begin : g_chan
      logic                 s1_reg;
      logic                 s2_reg;
      logic                 ch_clean_reg;
      logic                 ch_clean_next;
      logic [CNT_WIDTH-1:0] cnt_reg;
      logic [CNT_WIDTH-1:0] cnt_next;

      // Any cycle of agreement with the clean level restarts the window.
      always_comb begin
        cnt_next      = '0;
        ch_clean_next = ch_clean_reg;
        if (s2_reg != ch_clean_reg) begin
          if (cnt_reg == CNT_LAST) begin
            ch_clean_next = s2_reg;
          end else begin
            cnt_next = cnt_reg + CNT_WIDTH'(1);
          end
        end
      end

      always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
          s1_reg       <= 1'b0;
          s2_reg       <= 1'b0;
          cnt_reg      <= '0;
          ch_clean_reg <= 1'b0;
        end else begin
          s1_reg       <= raw_bus[gi];
          s2_reg       <= s1_reg;
          cnt_reg      <= cnt_next;
          ch_clean_reg <= ch_clean_next;
        end
      end

      assign clean_reg[gi]  = ch_clean_reg;
      assign clean_next[gi] = ch_clean_next;
    end
  endgenerate

  // Rise is taken from the same edge's clean update so the pulse lines up with it.
  logic       rise;
  logic       btnr_pulse_reg;
  logic       btnr_event_reg;
  logic [7:0] press_count_reg;

  assign rise = clean_next[16] & ~clean_reg[16];

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      btnr_pulse_reg  <= 1'b0;
      btnr_event_reg  <= 1'b0;
      press_count_reg <= 8'h00;
    end else begin
      btnr_pulse_reg <= rise;
      if (rise) begin
        btnr_event_reg  <= 1'b1;
        press_count_reg <= press_count_reg + 8'd1;
      end else if (io.event_clear) begin
        btnr_event_reg <= 1'b0;
      end
    end
  end

  assign io.sw_clean    = clean_reg[15:0];
  assign io.btnr_clean  = clean_reg[16];
  assign io.btnr_pulse  = btnr_pulse_reg;
  assign io.btnr_event  = btnr_event_reg;
  assign io.press_count = press_count_reg;

endmodule
